// File: rtl/wbdebounce.sv
// ---------------------------------------------------------------------------
// wbdebounce
//
// Wishbone-controlled input conditioner placed in front of the GPIO block.
// Each raw pin is synchronised through two flops and then debounced against a
// programmable stability period P: the clean level only follows the
// synchronised level after it has differed for P consecutive cycles.
// Clean-level changes latch rise/fall events that feed a maskable,
// registered interrupt.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_wb_cyc/stb/we/addr    wishbone request (2-bit word address)
//   i_wb_data               wishbone write data
//   o_wb_ack                one-cycle acknowledge, one cycle after the strobe
//   o_wb_stall              always 0
//   o_wb_data               registered read data, valid with o_wb_ack
//   i_pins                  raw asynchronous pins
//   o_clean                 debounced levels
//   o_int                   registered level interrupt
//
// Register map:
//   0 R     {s2 [31:16], clean [15:0]}
//   1 RW    period P (P = 0 acts as P = 1); a write restarts every count
//   2 R/W1C {fall [31:16], rise [15:0]}; a same-cycle set beats the clear
//   3 RW    interrupt enable mask, same layout as register 2
// ---------------------------------------------------------------------------
module wbdebounce #(
    parameter int             NIN            = 16,
    parameter int             CW             = 16,
    parameter logic [CW-1:0]  DEFAULT_PERIOD = CW'(1000)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [1:0]        i_wb_addr,
    input  logic [31:0]       i_wb_data,
    output logic              o_wb_ack,
    output logic              o_wb_stall,
    output logic [31:0]       o_wb_data,
    input  logic [NIN-1:0]    i_pins,
    output logic [NIN-1:0]    o_clean,
    output logic              o_int
);

    logic [NIN-1:0]          r_s1;
    logic [NIN-1:0]          r_s2;
    logic [NIN-1:0][CW-1:0]  r_cnt;
    logic [NIN-1:0]          r_clean;
    logic [CW-1:0]           r_period;
    logic [NIN-1:0]          r_rise;
    logic [NIN-1:0]          r_fall;
    logic [NIN-1:0]          r_maskRise;
    logic [NIN-1:0]          r_maskFall;
    logic                    r_int;
    logic                    r_ack;
    logic [31:0]             r_rdata;

    logic                    w_stb;
    logic                    w_wr;
    logic                    w_wrPeriod;
    logic                    w_wrEvent;
    logic                    w_wrMask;
    logic [CW-1:0]           w_lastCount;
    logic [NIN-1:0]          w_cleanNext;
    logic [NIN-1:0][CW-1:0]  w_cntNext;
    logic [NIN-1:0]          w_riseSet;
    logic [NIN-1:0]          w_fallSet;
    logic [NIN-1:0]          w_riseClr;
    logic [NIN-1:0]          w_fallClr;
    logic [31:0]             w_rdMux;

    assign w_stb      = i_wb_cyc & i_wb_stb;
    assign w_wr       = w_stb & i_wb_we;
    assign w_wrPeriod = w_wr && (i_wb_addr == 2'd1);
    assign w_wrEvent  = w_wr && (i_wb_addr == 2'd2);
    assign w_wrMask   = w_wr && (i_wb_addr == 2'd3);

    // P = 0 is treated like P = 1, so the terminal count is 0 in both cases.
    assign w_lastCount = (r_period == '0) ? '0 : (r_period - CW'(1));

    // Two-flop synchroniser per pin.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_pins;
            r_s2 <= r_s1;
        end
    end

    // Next-state of the debounce counters and clean levels. A period write
    // restarts every count and suppresses any update on that edge.
    always_comb begin
        w_cleanNext = r_clean;
        w_cntNext   = r_cnt;
        for (int i = 0; i < NIN; i++) begin
            if (w_wrPeriod) begin
                w_cntNext[i] = '0;
            end else if (r_s2[i] == r_clean[i]) begin
                w_cntNext[i] = '0;
            end else if (r_cnt[i] == w_lastCount) begin
                w_cleanNext[i] = r_s2[i];
                w_cntNext[i]   = '0;
            end else begin
                w_cntNext[i] = r_cnt[i] + CW'(1);
            end
        end
    end

    assign w_riseSet = w_cleanNext & ~r_clean;
    assign w_fallSet = ~w_cleanNext & r_clean;
    assign w_riseClr = w_wrEvent ? i_wb_data[NIN-1:0]   : '0;
    assign w_fallClr = w_wrEvent ? i_wb_data[16 +: NIN] : '0;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt   <= '0;
            r_clean <= '0;
        end else begin
            r_cnt   <= w_cntNext;
            r_clean <= w_cleanNext;
        end
    end

    // Event latches: set is OR-ed in after the clear so a simultaneous set wins.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= (r_rise & ~w_riseClr) | w_riseSet;
            r_fall <= (r_fall & ~w_fallClr) | w_fallSet;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_period   <= DEFAULT_PERIOD;
            r_maskRise <= '0;
            r_maskFall <= '0;
        end else begin
            if (w_wrPeriod) begin
                r_period <= i_wb_data[CW-1:0];
            end
            if (w_wrMask) begin
                r_maskRise <= i_wb_data[NIN-1:0];
                r_maskFall <= i_wb_data[16 +: NIN];
            end
        end
    end

    // The interrupt looks at the registered events, so it trails them by one edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_int <= 1'b0;
        end else begin
            r_int <= |((r_rise & r_maskRise) | (r_fall & r_maskFall));
        end
    end

    always_comb begin
        w_rdMux = '0;
        case (i_wb_addr)
            2'd0:    w_rdMux = {16'(r_s2), 16'(r_clean)};
            2'd1:    w_rdMux = 32'(r_period);
            2'd2:    w_rdMux = {16'(r_fall), 16'(r_rise)};
            default: w_rdMux = {16'(r_maskFall), 16'(r_maskRise)};
        endcase
    end

    // Read data captures register contents as they stand at the strobe edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_stb;
            if (w_stb) begin
                r_rdata <= w_rdMux;
            end
        end
    end

    assign o_wb_ack   = r_ack;
    assign o_wb_stall = 1'b0;
    assign o_wb_data  = r_rdata;
    assign o_clean    = r_clean;
    assign o_int      = r_int;

endmodule
